// File: rtl/logic_pod_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : logic_pod_ram_reader
// Purpose  : Reads a pod's DDR capture ring in 128-bit beats and serializes
//            them onto a 32-bit valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module logic_pod_ram_reader #(
    parameter logic [28:0] RING_BASE  = 29'h0000000,
    parameter logic [28:0] RING_LIMIT = 29'h0FFFFF8,
    parameter logic [28:0] ADDR_STEP  = 29'd8,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic         clk_ram,
    input  logic         rst,
    input  logic         start,
    input  logic [28:0]  start_addr,
    input  logic [23:0]  beat_count,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         ram_rd_en,
    output logic [28:0]  ram_rd_addr,
    input  logic         ram_rd_ack,
    input  logic         ram_rd_valid,
    input  logic [127:0] ram_rd_data,
    output logic         out_valid,
    output logic [31:0]  out_data,
    input  logic         out_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] c_depth = SW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t        r_state;
    logic [23:0]   r_req_left;
    logic [23:0]   r_ret_left;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_fifo_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [127:0]  r_mem [FIFO_DEPTH];
    logic [127:0]  r_shift;
    logic [1:0]    r_lane;
    logic          r_err;

    logic          w_active, w_abort_now, w_ack, w_ret_ok, w_wr;
    logic          w_last_acc, w_pop, w_credit;
    logic [CW-1:0] w_out_next, w_fifo_next;
    logic [23:0]   w_req_next;
    logic [28:0]   w_next_addr;

    always_comb begin
        w_active    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        w_abort_now = w_active && abort;
        w_ack       = ram_rd_en && ram_rd_ack;
        w_ret_ok    = ram_rd_valid && (r_outstanding != '0);
        w_wr        = w_ret_ok && w_active && !w_abort_now;
        w_last_acc  = out_valid && out_ready && (r_lane == 2'd3);
        w_pop       = (r_fifo_count != '0) && (!out_valid || w_last_acc) &&
                      w_active && !w_abort_now;
        w_out_next  = r_outstanding + CW'(w_ack) - CW'(w_ret_ok);
        w_fifo_next = r_fifo_count + CW'(w_wr) - CW'(w_pop);
        // Count this cycle's ack/pop so the registered request never overcommits
        w_credit    = ({1'b0, w_out_next} + {1'b0, w_fifo_next} + SW'(1)) <= c_depth;
        w_req_next  = r_req_left - 24'(w_ack);
        w_next_addr = (ram_rd_addr == RING_LIMIT) ? RING_BASE : ram_rd_addr + ADDR_STEP;
    end

    always_ff @(posedge clk_ram) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= ram_rd_data;
        end
    end

    always_ff @(posedge clk_ram) begin
        if (rst) begin
            r_state       <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_rd_en     <= 1'b0;
            ram_rd_addr   <= RING_BASE;
            out_valid     <= 1'b0;
            out_data      <= '0;
            r_req_left    <= '0;
            r_ret_left    <= '0;
            r_outstanding <= '0;
            r_fifo_count  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_shift       <= '0;
            r_lane        <= '0;
            r_err         <= 1'b0;
        end else begin
            done          <= 1'b0;
            r_err         <= r_err | (ram_rd_valid && (r_outstanding == '0));
            r_outstanding <= w_out_next;
            r_req_left    <= w_req_next;
            r_fifo_count  <= w_fifo_next;
            if (w_ack) begin
                ram_rd_addr <= w_next_addr;
            end
            if (w_wr) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_ret_left <= r_ret_left - 24'd1;
            end

            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                out_data  <= r_mem[r_rd_ptr][31:0];
                out_valid <= 1'b1;
                r_lane    <= 2'd0;
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end else if (out_valid && out_ready) begin
                if (r_lane == 2'd3) begin
                    out_valid <= 1'b0;
                end else begin
                    out_data <= r_shift[63:32];
                    r_shift  <= {32'h0, r_shift[127:32]};
                    r_lane   <= r_lane + 2'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        ram_rd_addr <= start_addr;
                        r_req_left  <= beat_count;
                        r_ret_left  <= beat_count;
                        busy        <= 1'b1;
                        if (beat_count == 24'd0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            ram_rd_en <= 1'b1;
                        end
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    if (abort) begin
                        r_state      <= S_ABORT;
                        ram_rd_en    <= 1'b0;
                        out_valid    <= 1'b0;
                        r_fifo_count <= '0;
                        r_wr_ptr     <= '0;
                        r_rd_ptr     <= '0;
                    end else if (r_state == S_ISSUE) begin
                        if (w_req_next == 24'd0) begin
                            r_state   <= S_DRAIN;
                            ram_rd_en <= 1'b0;
                        end else begin
                            ram_rd_en <= w_credit;
                        end
                    end else if ((r_ret_left == 24'd0) && (r_fifo_count == '0) &&
                                 (!out_valid || w_last_acc)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_ABORT: begin
                    // Stay until every request already granted has come back
                    if (w_out_next == '0) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
